// File: rtl/csr_timer_unit.sv
// csr_timer_unit: N-channel down-counting timers with per-channel TCFG/TVAL/TICLR and a shared TID register.
module csr_timer_unit #(
  parameter int N_TIMER = 1,
  parameter int CNT_W = 32,
  parameter logic [13:0] CSR_BASE = 14'h41,
  parameter logic [13:0] TID_ADDR = 14'h40
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [13:0]        csr_num,
  input  logic               csr_we,
  input  logic [31:0]        csr_wmask,
  input  logic [31:0]        csr_wvalue,
  output logic [31:0]        csr_rvalue,
  output logic               csr_hit,
  input  logic               cnt_freeze,
  output logic [N_TIMER-1:0] timer_int,
  output logic               timer_int_any
);
  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE = 1;
  logic [31:0] tid;
  logic [31:0] rd_ch [N_TIMER];
  logic [N_TIMER-1:0] hit_ch;
  logic hit_tid;
  assign hit_tid = csr_num == TID_ADDR;
  for (genvar i = 0; i < N_TIMER; i++) begin : g_ch
    localparam logic [13:0] BASE = CSR_BASE + 14'(8 * i);
    logic en, periodic, pend, hit_cfg, hit_val, hit_clr, reload, set_pend, clr_pend;
    logic [CNT_W-3:0] initval;
    logic [CNT_W-1:0] cnt, cfg, merged;
    assign hit_cfg = csr_num == BASE;
    assign hit_val = csr_num == BASE + 14'd1;
    assign hit_clr = csr_num == BASE + 14'd3;
    assign hit_ch[i] = hit_cfg | hit_val | hit_clr;
    assign cfg = {initval, periodic, en};
    assign merged = (csr_wmask[CNT_W-1:0] & csr_wvalue[CNT_W-1:0]) | (~csr_wmask[CNT_W-1:0] & cfg);
    // An enabling TCFG write reloads even under freeze and suppresses this edge's interrupt.
    assign reload = csr_we && hit_cfg && merged[0];
    assign set_pend = en && !cnt_freeze && cnt == '0 && !reload;
    assign clr_pend = csr_we && hit_clr && csr_wmask[0] && csr_wvalue[0];
    assign rd_ch[i] = hit_cfg ? 32'(cfg) : hit_val ? 32'(cnt) : '0;
    assign timer_int[i] = pend;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        en <= 1'b0;
        periodic <= 1'b0;
        initval <= '0;
        cnt <= ONES;
        pend <= 1'b0;
      end else begin
        if (csr_we && hit_cfg) {initval, periodic, en} <= merged;
        cnt <= reload ? {merged[CNT_W-1:2], 2'b00}
             : (cnt_freeze || !en || cnt == ONES) ? cnt
             : (cnt == '0 && periodic) ? {initval, 2'b00}
             : cnt - ONE;
        pend <= set_pend || (pend && !clr_pend);
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tid <= '0;
    else if (csr_we && hit_tid) tid <= (csr_wmask & csr_wvalue) | (~csr_wmask & tid);
  end
  always_comb begin
    csr_rvalue = hit_tid ? tid : '0;
    for (int i = 0; i < N_TIMER; i++) csr_rvalue = csr_rvalue | rd_ch[i];
  end
  assign csr_hit = hit_tid | (|hit_ch);
  assign timer_int_any = |timer_int;
endmodule

// File: tb/tb_csr_timer_unit.sv
// tb_csr_timer_unit: directed and random checks of a 2-channel, 16-bit csr_timer_unit against a behavioural model.
module tb_csr_timer_unit;
  localparam int ALL = 'hFFFF;
  logic clk, resetn, csr_we, csr_hit, cnt_freeze, timer_int_any;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue, csr_rvalue;
  logic [1:0] timer_int;
  int n_chk = 0, n_fail = 0;
  int m_cnt [2], m_init [2];
  bit m_en [2], m_per [2], m_pend [2];
  logic [31:0] m_tid;

  csr_timer_unit #(.N_TIMER(2), .CNT_W(16), .CSR_BASE(14'h41), .TID_ADDR(14'h40)) dut (
    .clk(clk), .resetn(resetn), .csr_num(csr_num), .csr_we(csr_we), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue), .csr_hit(csr_hit), .cnt_freeze(cnt_freeze),
    .timer_int(timer_int), .timer_int_any(timer_int_any)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int base(input int i);
    return 'h41 + 8 * i;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = ALL; m_init[i] = 0; m_en[i] = 0; m_per[i] = 0; m_pend[i] = 0;
    end
    m_tid = 0;
  endtask

  task automatic model_read(input int a, output logic h, output logic [31:0] v);
    h = (a == 'h40); v = (a == 'h40) ? m_tid : 0;
    for (int i = 0; i < 2; i++) begin
      if (a == base(i)) begin h = 1; v = m_init[i] * 4 + m_per[i] * 2 + m_en[i]; end
      if (a == base(i) + 1) begin h = 1; v = m_cnt[i]; end
      if (a == base(i) + 3) begin h = 1; v = 0; end
    end
  endtask

  task automatic model_step(input logic we, input int a, input logic [31:0] mask, input logic [31:0] val, input logic frz);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] old, mrg;
      bit cfgw, reload, setp, clrp;
      int nc;
      old = m_init[i] * 4 + m_per[i] * 2 + m_en[i];
      mrg = ((mask & val) | (~mask & old)) & ALL;
      cfgw = we && a == base(i);
      reload = cfgw && mrg[0];
      setp = m_en[i] && !frz && m_cnt[i] == 0 && !reload;
      clrp = we && a == base(i) + 3 && mask[0] && val[0];
      if (reload) nc = (mrg / 4) * 4;
      else if (frz || !m_en[i] || m_cnt[i] == ALL) nc = m_cnt[i];
      else if (m_cnt[i] == 0) nc = m_per[i] ? m_init[i] * 4 : ALL;
      else nc = m_cnt[i] - 1;
      m_cnt[i] = nc;
      m_pend[i] = setp ? 1 : clrp ? 0 : m_pend[i];
      if (cfgw) begin m_en[i] = mrg[0]; m_per[i] = mrg[1]; m_init[i] = mrg / 4; end
    end
    if (we && a == 'h40) m_tid = (mask & val) | (~mask & m_tid);
  endtask

  task automatic tick(input logic we, input logic [13:0] a, input logic [31:0] mask, input logic [31:0] val, input logic frz);
    logic h;
    logic [31:0] v;
    csr_we = we; csr_num = a; csr_wmask = mask; csr_wvalue = val; cnt_freeze = frz;
    @(negedge clk);
    model_read(a, h, v);
    chk("hit", csr_hit, h);
    chk("rvalue", csr_rvalue, v);
    chk("timer_int", timer_int, {m_pend[1], m_pend[0]});
    chk("timer_int_any", timer_int_any, m_pend[0] | m_pend[1]);
    @(posedge clk);
    model_step(we, a, mask, val, frz);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 14'h42, 0, 0, 0);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] mask, input logic [31:0] val);
    tick(1, a, mask, val, 0);
  endtask

  task automatic peek(input string tag, input logic [13:0] a, input logic [31:0] exp);
    csr_we = 0; cnt_freeze = 0; csr_num = a;
    #1;
    chk(tag, csr_rvalue, exp);
  endtask

  initial begin
    logic [13:0] addrs [12];
    int v;
    addrs = '{14'h40, 14'h41, 14'h42, 14'h44, 14'h49, 14'h4A, 14'h4C, 14'h43, 14'h4B, 14'h45, 14'h3F, 14'h51};
    resetn = 0; csr_we = 0; csr_num = 0; csr_wmask = 0; csr_wvalue = 0; cnt_freeze = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 resetn = 1;
    @(posedge clk); #1;
    peek("rst_tval0", 14'h42, 32'hFFFF);
    peek("rst_tcfg0", 14'h41, 0);
    peek("rst_tid", 14'h40, 0);
    chk("rst_int", timer_int, 0);

    wr(14'h41, 32'hFFFFFFFF, 32'h15);
    for (int k = 20; k >= 0; k--) begin
      peek("oneshot_tval", 14'h42, k);
      tick(0, 14'h42, 0, 0, 0);
    end
    peek("oneshot_wrap", 14'h42, 32'hFFFF);
    chk("oneshot_int", timer_int[0], 1);
    idle(3);
    peek("oneshot_hold", 14'h42, 32'hFFFF);
    wr(14'h44, 32'hFFFFFFFF, 1);
    chk("ticlr", timer_int[0], 0);

    wr(14'h41, 32'hFFFFFFFF, 32'hB);
    peek("per_start", 14'h42, 8);
    idle(8);
    peek("per_zero", 14'h42, 0);
    wr(14'h44, 32'hFFFFFFFF, 1);
    chk("set_wins", timer_int[0], 1);
    peek("per_reload", 14'h42, 8);
    wr(14'h44, 32'h1, 32'h1);
    chk("per_clr", timer_int[0], 0);

    wr(14'h41, 32'h1, 32'h0);
    peek("mask_tcfg", 14'h41, 32'hA);
    v = csr_rvalue;
    peek("mask_tval", 14'h42, 6);
    idle(3);
    peek("mask_frozen", 14'h42, 6);
    wr(14'h41, 32'h1, 32'h1);
    peek("mask_reload", 14'h42, 8);
    peek("mask_tcfg2", 14'h41, 32'hB);

    idle(8);
    for (int k = 0; k < 10; k++) tick(0, 14'h42, 0, 0, 1);
    peek("frz_hold", 14'h42, 0);
    chk("frz_nopend", timer_int[0], 0);
    idle(1);
    chk("frz_release", timer_int[0], 1);

    wr(14'h41, 32'hFFFFFFFF, 0);
    wr(14'h44, 32'hFFFFFFFF, 1);
    wr(14'h49, 32'hFFFFFFFF, 32'h1D);
    wr(14'h41, 32'hFFFFFFFF, 32'hD);
    peek("mc_tval1", 14'h4A, 27);
    peek("mc_tval0", 14'h42, 12);
    idle(13);
    chk("mc_int0", timer_int, 2'b01);
    chk("mc_any0", timer_int_any, 1);
    idle(15);
    chk("mc_int_both", timer_int, 2'b11);
    wr(14'h44, 32'hFFFFFFFF, 1);
    chk("mc_int1", timer_int, 2'b10);
    chk("mc_any1", timer_int_any, 1);
    wr(14'h4C, 32'hFFFFFFFF, 1);
    chk("mc_any_none", timer_int_any, 0);
    tick(0, 14'h4B, 0, 0, 0);
    peek("mc_hole", 14'h4B, 0);
    chk("mc_hole_hit", csr_hit, 0);
    wr(14'h40, 32'hFFFF0000, 32'hDEADBEEF);
    peek("tid", 14'h40, 32'hDEAD0000);

    for (int k = 0; k < 3000; k++) begin
      logic [13:0] a;
      logic [31:0] mask, val;
      int r;
      a = addrs[$urandom_range(0, 11)];
      r = $urandom_range(0, 2);
      mask = r == 0 ? 32'hFFFFFFFF : r == 1 ? 32'h1 : $urandom;
      val = $urandom;
      if (a == 14'h41 || a == 14'h49) val = val & 32'h3F;
      tick($urandom_range(0, 3) == 0, a, mask, val, $urandom_range(0, 9) == 0);
    end

    wr(14'h41, 32'hFFFFFFFF, 32'h5);
    wr(14'h49, 32'hFFFFFFFF, 32'h9);
    idle(5);
    chk("pre_rst_int", timer_int[0], 1);
    #2 resetn = 0;
    #1;
    chk("arst_int", timer_int, 0);
    chk("arst_any", timer_int_any, 0);
    model_reset();
    @(posedge clk);
    #3 resetn = 1;
    peek("arst_tval0", 14'h42, 32'hFFFF);
    peek("arst_tcfg0", 14'h41, 0);
    peek("arst_tid", 14'h40, 0);
    @(posedge clk); #1;
    peek("arst_tval1", 14'h4A, 32'hFFFF);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
